// File: rtl/vram_port_arbiter.sv
// Arbitrates the single VRAM BRAM port between video character fetch (strict priority)
// and the register-bus access path. Define ARB_STALL_COUNT_EN to build the stall counter.
module vram_port_arbiter #(
    parameter int VRAM_WORDS = 1200,
    parameter int AW         = 11,
    parameter int STALL_W    = 16
) (
    input  logic               axi_aclk,
    input  logic               axi_aresetn,
    input  logic               vid_req,
    input  logic [AW-1:0]      vid_addr,
    output logic               vid_rvalid,
    output logic [31:0]        vid_rdata,
    input  logic               bus_valid,
    output logic               bus_ready,
    input  logic               bus_we,
    input  logic [AW-1:0]      bus_addr,
    input  logic [31:0]        bus_wdata,
    input  logic [3:0]         bus_wstrb,
    output logic               bus_wack,
    output logic               bus_rvalid,
    input  logic               bus_rready,
    output logic [31:0]        bus_rdata,
    output logic               bus_err,
    output logic               mem_en,
    output logic [3:0]         mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {IDLE, WR, RD1, RD2, RV} state_t;

    localparam logic [AW:0] WORDS_L = VRAM_WORDS[AW:0];

    state_t state;
    logic   bus_hs;
    logic   oor;
    logic   err_p0;
    logic   vid_vld_p0;

    assign bus_ready = bus_valid && !vid_req && (state == IDLE);
    assign bus_hs    = bus_valid && bus_ready;
    assign oor       = ({1'b0, bus_addr} >= WORDS_L);
    assign vid_rdata = vid_rvalid ? mem_rdata : 32'd0;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state      <= IDLE;
            err_p0     <= 1'b0;
            vid_vld_p0 <= 1'b0;
            vid_rvalid <= 1'b0;
            bus_wack   <= 1'b0;
            bus_rvalid <= 1'b0;
            bus_rdata  <= 32'd0;
            bus_err    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 4'd0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
        end else begin
            mem_en     <= 1'b0;
            mem_we     <= 4'd0;
            bus_wack   <= 1'b0;
            // stage p0: port grant; p1: BRAM access; p2: read data on mem_rdata
            vid_vld_p0 <= vid_req;
            vid_rvalid <= vid_vld_p0;
            if (vid_req) begin
                mem_en   <= 1'b1;
                mem_addr <= vid_addr;
            end else if (bus_hs && !oor) begin
                mem_en    <= 1'b1;
                mem_addr  <= bus_addr;
                mem_we    <= bus_we ? bus_wstrb : 4'd0;
                mem_wdata <= bus_wdata;
            end
            case (state)
                IDLE: begin
                    if (bus_hs) begin
                        err_p0 <= oor;
                        if (bus_we) begin
                            state    <= WR;
                            bus_wack <= 1'b1;
                            bus_err  <= oor;
                        end else begin
                            state <= RD1;
                        end
                    end
                end
                WR: begin
                    state   <= IDLE;
                    bus_err <= 1'b0;
                end
                RD1: state <= RD2;
                RD2: begin
                    // out-of-range reads never touched the BRAM, so mem_rdata is not ours
                    bus_rdata  <= err_p0 ? 32'd0 : mem_rdata;
                    bus_err    <= err_p0;
                    bus_rvalid <= 1'b1;
                    state      <= RV;
                end
                RV: begin
                    if (bus_rready) begin
                        bus_rvalid <= 1'b0;
                        bus_err    <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STALL_COUNT_EN
    logic [STALL_W-1:0] stall_q;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            stall_q <= '0;
        end else if (bus_hs && !bus_wack && !bus_rvalid) begin
            stall_q <= '0;
        end else if (bus_valid && !bus_ready && (state == IDLE) && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter with a behavioural 1-cycle-latency BRAM.
module tb_vram_port_arbiter;

    localparam int AW    = 11;
    localparam int SW    = 16;
    localparam int WORDS = 1200;
`ifdef ARB_STALL_COUNT_EN
    localparam int EXP_STALL = 10;
`else
    localparam int EXP_STALL = 0;
`endif

    logic          axi_aclk = 1'b0;
    logic          axi_aresetn = 1'b0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_rvalid;
    logic [31:0]   vid_rdata;
    logic          bus_valid = 1'b0;
    logic          bus_ready;
    logic          bus_we = 1'b0;
    logic [AW-1:0] bus_addr = '0;
    logic [31:0]   bus_wdata = '0;
    logic [3:0]    bus_wstrb = '0;
    logic          bus_wack;
    logic          bus_rvalid;
    logic          bus_rready = 1'b0;
    logic [31:0]   bus_rdata;
    logic          bus_err;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic [SW-1:0] stall_cnt;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        rd_q[$];
    logic [31:0] bram   [0:WORDS-1];
    logic [31:0] shadow [0:WORDS-1];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 axi_aclk = ~axi_aclk;

    vram_port_arbiter #(.VRAM_WORDS(WORDS), .AW(AW), .STALL_W(SW)) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_wack(bus_wack),
        .bus_rvalid(bus_rvalid), .bus_rready(bus_rready), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    always @(posedge axi_aclk) begin
        if (mem_en && int'(mem_addr) < WORDS) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= bram[mem_addr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [132:0] all_outs();
        return {vid_rvalid, vid_rdata, bus_ready, bus_wack, bus_rvalid, bus_rdata, bus_err,
                mem_en, mem_we, mem_addr, mem_wdata, stall_cnt};
    endfunction

    task automatic step();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic drv_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int hs_wait, output logic m_en, output logic [3:0] m_we,
                             output logic [AW-1:0] m_addr, output logic [31:0] m_wd,
                             output logic wack, output logic err);
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d; bus_wstrb = s;
        #1;
        hs_wait = 0;
        while (!bus_ready && hs_wait < 50) begin
            step();
            hs_wait++;
        end
        step();
        bus_valid = 1'b0; bus_we = 1'b0;
        m_en = mem_en; m_we = mem_we; m_addr = mem_addr; m_wd = mem_wdata;
        wack = bus_wack; err = bus_err;
        step();
    endtask

    task automatic drv_read(input logic [AW-1:0] a, input int hold, output int hs_wait,
                            output logic m_en, output int lat, output logic [31:0] rd,
                            output logic err, output logic stable, output logic rv_after);
        bus_valid = 1'b1; bus_we = 1'b0; bus_addr = a; bus_rready = 1'b0;
        #1;
        hs_wait = 0;
        while (!bus_ready && hs_wait < 50) begin
            step();
            hs_wait++;
        end
        step();
        bus_valid = 1'b0;
        m_en = mem_en;
        lat = 1;
        while (!bus_rvalid && lat < 20) begin
            step();
            lat++;
        end
        rd = bus_rdata; err = bus_err; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            if (!bus_rvalid || bus_rdata !== rd || bus_err !== err) stable = 1'b0;
        end
        bus_rready = 1'b1;
        step();
        bus_rready = 1'b0;
        rv_after = bus_rvalid;
    endtask

    task automatic test_reset();
        axi_aresetn = 1'b0;
        repeat (3) step();
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", all_outs());
        end
        axi_aresetn = 1'b1;
        step();
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL post_release_outputs: got %h, want 0", all_outs());
        end
    endtask

    task automatic test_write_read();
        int hs, lat; logic men, wack, err, stab, rva; logic [3:0] mwe;
        logic [AW-1:0] ma; logic [31:0] mwd, rd; exp_t e;
        drv_write(11'd5, 32'hDEADBEEF, 4'hF, hs, men, mwe, ma, mwd, wack, err);
        shadow[5] = 32'hDEADBEEF;
        n_checks++;
        if ({hs == 0, men, mwe, ma, mwd, wack, err} !== {1'b1, 1'b1, 4'hF, 11'd5, 32'hDEADBEEF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL write5: hs=%0d en=%b we=%h addr=%0d wd=%h wack=%b err=%b, want hs=0 en=1 we=f addr=5 wd=deadbeef wack=1 err=0",
                     hs, men, mwe, ma, mwd, wack, err);
        end
        rd_q.push_back('{data: shadow[5], err: 1'b0});
        drv_read(11'd5, 0, hs, men, lat, rd, err, stab, rva);
        e = rd_q.pop_front();
        n_checks++;
        if ({rd, err} !== {e.data, e.err}) begin
            n_fail++;
            $display("FAIL read5_data: got %h err=%b, want %h err=%b", rd, err, e.data, e.err);
        end
        n_checks++;
        if ({lat, men, rva} !== {32'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL read5_timing: lat=%0d en=%b rvalid_after=%b, want lat=3 en=1 rvalid_after=0", lat, men, rva);
        end
    endtask

    task automatic test_byte_write();
        int hs, lat; logic men, wack, err, stab, rva; logic [3:0] mwe;
        logic [AW-1:0] ma; logic [31:0] mwd, rd; exp_t e;
        drv_write(11'd7, 32'h11223344, 4'hF, hs, men, mwe, ma, mwd, wack, err);
        shadow[7] = 32'h11223344;
        drv_write(11'd7, 32'h000000AA, 4'h1, hs, men, mwe, ma, mwd, wack, err);
        shadow[7] = merge(shadow[7], 32'h000000AA, 4'h1);
        n_checks++;
        if ({men, mwe, wack, err} !== {1'b1, 4'h1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL byte_write_port: en=%b we=%h wack=%b err=%b, want 1 1 1 0", men, mwe, wack, err);
        end
        drv_write(11'd7, 32'hFFFFFFFF, 4'h0, hs, men, mwe, ma, mwd, wack, err);
        n_checks++;
        if ({men, mwe, wack, err} !== {1'b1, 4'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_strobe_write: en=%b we=%h wack=%b err=%b, want 1 0 1 0", men, mwe, wack, err);
        end
        rd_q.push_back('{data: shadow[7], err: 1'b0});
        drv_read(11'd7, 0, hs, men, lat, rd, err, stab, rva);
        e = rd_q.pop_front();
        n_checks++;
        if (rd !== e.data || rd !== 32'h112233AA || err !== e.err) begin
            n_fail++;
            $display("FAIL byte_readback: got %h err=%b, want 112233aa err=0", rd, err);
        end
    endtask

    task automatic test_vid_priority();
        int hs; logic men, wack, err; logic [3:0] mwe; logic [AW-1:0] ma; logic [31:0] mwd; exp_t e;
        drv_write(11'd9, 32'hCAFE0009, 4'hF, hs, men, mwe, ma, mwd, wack, err);
        shadow[9] = 32'hCAFE0009;
        drv_write(11'd3, 32'h33330003, 4'hF, hs, men, mwe, ma, mwd, wack, err);
        shadow[3] = 32'h33330003;
        vid_req = 1'b1; vid_addr = 11'd9;
        bus_valid = 1'b1; bus_we = 1'b0; bus_addr = 11'd3;
        #1;
        n_checks++;
        if (bus_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_ready: got %b, want 0", bus_ready);
        end
        step();
        vid_req = 1'b0;
        #1;
        n_checks++;
        if ({mem_en, mem_we, mem_addr, vid_rvalid, bus_ready} !== {1'b1, 4'h0, 11'd9, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL conflict_vid_grant: en=%b we=%h addr=%0d vrv=%b ready=%b, want 1 0 9 0 1",
                     mem_en, mem_we, mem_addr, vid_rvalid, bus_ready);
        end
        rd_q.push_back('{data: shadow[3], err: 1'b0});
        step();
        bus_valid = 1'b0;
        n_checks++;
        if ({vid_rvalid, vid_rdata, mem_en, mem_addr} !== {1'b1, shadow[9], 1'b1, 11'd3}) begin
            n_fail++;
            $display("FAIL conflict_vid_data: vrv=%b vdata=%h en=%b addr=%0d, want 1 %h 1 3",
                     vid_rvalid, vid_rdata, mem_en, mem_addr, shadow[9]);
        end
        step();
        step();
        e = rd_q.pop_front();
        n_checks++;
        if ({bus_rvalid, bus_rdata, bus_err} !== {1'b1, e.data, e.err}) begin
            n_fail++;
            $display("FAIL conflict_bus_read: rvalid=%b data=%h err=%b, want 1 %h %b", bus_rvalid, bus_rdata, bus_err, e.data, e.err);
        end
        bus_rready = 1'b1;
        step();
        bus_rready = 1'b0;
    endtask

    task automatic test_out_of_range();
        int hs, lat; logic men, wack, err, stab, rva; logic [3:0] mwe;
        logic [AW-1:0] ma; logic [31:0] mwd, rd; exp_t e;
        drv_write(11'd1200, 32'h1, 4'hF, hs, men, mwe, ma, mwd, wack, err);
        n_checks++;
        if ({men, mwe, wack, err} !== {1'b0, 4'h0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL oor_write: en=%b we=%h wack=%b err=%b, want 0 0 1 1", men, mwe, wack, err);
        end
        rd_q.push_back('{data: 32'd0, err: 1'b1});
        drv_read(11'd2047, 0, hs, men, lat, rd, err, stab, rva);
        e = rd_q.pop_front();
        n_checks++;
        if ({rd, err, men, lat} !== {e.data, e.err, 1'b0, 32'd3}) begin
            n_fail++;
            $display("FAIL oor_read: data=%h err=%b en=%b lat=%0d, want 0 1 0 3", rd, err, men, lat);
        end
        drv_write(11'd1199, 32'hABCD1199, 4'hF, hs, men, mwe, ma, mwd, wack, err);
        shadow[1199] = 32'hABCD1199;
        rd_q.push_back('{data: shadow[1199], err: 1'b0});
        drv_read(11'd1199, 0, hs, men, lat, rd, err, stab, rva);
        e = rd_q.pop_front();
        n_checks++;
        if ({rd, err, men} !== {e.data, e.err, 1'b1}) begin
            n_fail++;
            $display("FAIL last_word: data=%h err=%b en=%b, want %h 0 1", rd, err, men, e.data);
        end
    endtask

    task automatic test_rready_hold();
        logic [31:0] held; exp_t e;
        bus_valid = 1'b1; bus_we = 1'b0; bus_addr = 11'd5; bus_rready = 1'b0;
        #1;
        rd_q.push_back('{data: shadow[5], err: 1'b0});
        step();
        bus_valid = 1'b0;
        step();
        step();
        held = bus_rdata;
        for (int i = 0; i < 5; i++) begin
            vid_req = (i == 1); vid_addr = 11'd9;
            bus_valid = 1'b1; bus_we = 1'b1; bus_addr = 11'd50; bus_wdata = 32'h5; bus_wstrb = 4'hF;
            #1;
            n_checks++;
            if ({bus_ready, bus_rvalid, bus_rdata} !== {1'b0, 1'b1, held}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: ready=%b rvalid=%b data=%h, want 0 1 %h", i, bus_ready, bus_rvalid, bus_rdata, held);
            end
            if (i == 3) begin
                n_checks++;
                if ({vid_rvalid, vid_rdata} !== {1'b1, shadow[9]}) begin
                    n_fail++;
                    $display("FAIL hold_vid: vrv=%b vdata=%h, want 1 %h", vid_rvalid, vid_rdata, shadow[9]);
                end
            end
            step();
        end
        vid_req = 1'b0; bus_valid = 1'b0; bus_we = 1'b0; bus_rready = 1'b1;
        #1;
        e = rd_q.pop_front();
        n_checks++;
        if ({bus_rvalid, bus_rdata, bus_err, bus_wack} !== {1'b1, e.data, e.err, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_result: rvalid=%b data=%h err=%b wack=%b, want 1 %h 0 0", bus_rvalid, bus_rdata, bus_err, bus_wack, e.data);
        end
        step();
        bus_rready = 1'b0;
        n_checks++;
        if (bus_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: rvalid=%b, want 0", bus_rvalid);
        end
    endtask

    task automatic test_stall();
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = 11'd20; bus_wdata = 32'h20202020; bus_wstrb = 4'hF;
        for (int i = 0; i < 10; i++) begin
            vid_req = 1'b1; vid_addr = 11'd5;
            #1;
            n_checks++;
            if (bus_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_ready%0d: got %b, want 0", i, bus_ready);
            end
            if (i >= 2) begin
                n_checks++;
                if ({vid_rvalid, vid_rdata} !== {1'b1, shadow[5]}) begin
                    n_fail++;
                    $display("FAIL stall_vid%0d: vrv=%b vdata=%h, want 1 %h", i, vid_rvalid, vid_rdata, shadow[5]);
                end
            end
            step();
        end
        vid_req = 1'b0;
        #1;
        n_checks++;
        if ({bus_ready, stall_cnt} !== {1'b1, 16'(EXP_STALL)}) begin
            n_fail++;
            $display("FAIL stall_grant: ready=%b stall_cnt=%0d, want 1 %0d", bus_ready, stall_cnt, EXP_STALL);
        end
        step();
        bus_valid = 1'b0; bus_we = 1'b0;
        shadow[20] = 32'h20202020;
        n_checks++;
        if ({bus_wack, mem_en, mem_we, mem_addr, vid_rvalid} !== {1'b1, 1'b1, 4'hF, 11'd20, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_write: wack=%b en=%b we=%h addr=%0d vrv=%b, want 1 1 f 20 1",
                     bus_wack, mem_en, mem_we, mem_addr, vid_rvalid);
        end
        step();
        n_checks++;
        if ({vid_rvalid, stall_cnt} !== {1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL stall_clear: vrv=%b stall_cnt=%0d, want 0 0", vid_rvalid, stall_cnt);
        end
    endtask

    task automatic test_random_traffic();
        int hs, lat; logic men, wack, err, stab, rva; logic [3:0] mwe, s;
        logic [AW-1:0] ma, a; logic [31:0] mwd, rd, d; exp_t e; logic is_oor;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            drv_write(11'(100 + i), d, 4'hF, hs, men, mwe, ma, mwd, wack, err);
            shadow[100 + i] = d;
        end
        for (int i = 0; i < 40; i++) begin
            is_oor = ($urandom_range(0, 7) == 0);
            a = is_oor ? 11'(1200 + $urandom_range(0, 847)) : 11'(100 + $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; s = 4'($urandom_range(0, 15));
                drv_write(a, d, s, hs, men, mwe, ma, mwd, wack, err);
                if (!is_oor) shadow[a] = merge(shadow[a], d, s);
                n_checks++;
                if ({hs, wack, err, men} !== {32'd0, 1'b1, is_oor, !is_oor}) begin
                    n_fail++;
                    $display("FAIL rand_write%0d addr=%0d: hs=%0d wack=%b err=%b en=%b, want 0 1 %b %b",
                             i, a, hs, wack, err, men, is_oor, !is_oor);
                end
            end else begin
                rd_q.push_back('{data: is_oor ? 32'd0 : shadow[a], err: is_oor});
                drv_read(a, i % 3, hs, men, lat, rd, err, stab, rva);
                e = rd_q.pop_front();
                n_checks++;
                if ({rd, err, lat, stab, rva} !== {e.data, e.err, 32'd3, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rand_read%0d addr=%0d: data=%h err=%b lat=%0d stable=%b rv_after=%b, want %h %b 3 1 0",
                             i, a, rd, err, lat, stab, rva, e.data, e.err);
                end
            end
        end
    endtask

    task automatic test_reset_mid_rv();
        int hs, lat; logic men, err, stab, rva; logic [31:0] rd; exp_t e; logic stale;
        bus_valid = 1'b1; bus_we = 1'b0; bus_addr = 11'd5;
        #1;
        step();
        bus_valid = 1'b0;
        step();
        step();
        vid_req = 1'b1; vid_addr = 11'd9;
        step();
        vid_req = 1'b0;
        #1;
        axi_aresetn = 1'b0;
        #1;
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_rv: got %h, want 0", all_outs());
        end
        step();
        step();
        axi_aresetn = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (vid_rvalid || bus_wack || bus_rvalid || mem_en) stale = 1'b1;
        end
        n_checks++;
        if (stale !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stale: got stale=%b, want 0", stale);
        end
        rd_q.push_back('{data: shadow[5], err: 1'b0});
        drv_read(11'd5, 0, hs, men, lat, rd, err, stab, rva);
        e = rd_q.pop_front();
        n_checks++;
        if ({rd, err, lat} !== {e.data, e.err, 32'd3}) begin
            n_fail++;
            $display("FAIL reset_recovery: data=%h err=%b lat=%0d, want %h 0 3", rd, err, lat, e.data);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_vid_priority();
        test_out_of_range();
        test_rready_hold();
        test_stall();
        test_random_traffic();
        test_reset_mid_rv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
